// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: byte request handshakes for two requesters (A, B).
// master = byte producers, slave = the scheduler.
interface uart_tx_sched_if #(
    parameter int DATA_W = 8
);
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin A/B byte scheduler onto one 8N1/8N2 UART line.
// Define UART_TX_SCHED_PARITY_EN for an even-parity bit (8E1/8E2).
module uart_tx_sched #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           baud_tick,
    uart_tx_sched_if.slave req,
    output logic           tx,
    output logic           busy,
    output logic           grant_src
);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
`ifdef UART_TX_SCHED_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     bit_idx;
    logic              stop_cnt;
    logic              prio_b;
    logic              pick_b;
    logic              a_hs;
    logic              b_hs;
`ifdef UART_TX_SCHED_PARITY_EN
    logic              par_bit;
`endif

    // B wins when alone, or when both ask and A was served last
    assign pick_b      = req.b_valid & (~req.a_valid | prio_b);
    assign req.a_ready = (state == IDLE) & ~rst & req.a_valid & ~pick_b;
    assign req.b_ready = (state == IDLE) & ~rst & pick_b;
    assign a_hs        = req.a_ready;
    assign b_hs        = req.b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            grant_src <= 1'b0;
            prio_b    <= 1'b0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (a_hs || b_hs) begin
                        shreg     <= b_hs ? req.b_data : req.a_data;
`ifdef UART_TX_SCHED_PARITY_EN
                        par_bit   <= b_hs ? ^req.b_data : ^req.a_data;
`endif
                        grant_src <= b_hs;
                        prio_b    <= ~b_hs;
                        busy      <= 1'b1;
                        state     <= SYNC;
                    end
                end
                SYNC: begin
                    if (baud_tick) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_SCHED_PARITY_EN
                            state <= PARITY;
                            tx    <= par_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            // shreg[0] is always the bit now on the line
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_SCHED_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            stop_cnt <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: two schedulers (1 and 2 stop bits) checked every
// cycle against a frame-list model, plus literal frame expectations.
module tb_uart_tx_sched;
    localparam int DW = 8;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic baud_tick;
    always #5 clk = ~clk;

    logic [1:0] av, bv, ar, br, tx, busy, gsrc;
    logic [7:0] ad [2];
    logic [7:0] bd [2];

    uart_tx_sched_if #(.DATA_W(DW)) ifc0 ();
    uart_tx_sched_if #(.DATA_W(DW)) ifc1 ();

    assign ifc0.a_valid = av[0];
    assign ifc0.a_data  = ad[0];
    assign ifc0.b_valid = bv[0];
    assign ifc0.b_data  = bd[0];
    assign ifc1.a_valid = av[1];
    assign ifc1.a_data  = ad[1];
    assign ifc1.b_valid = bv[1];
    assign ifc1.b_data  = bd[1];
    assign ar[0] = ifc0.a_ready;
    assign br[0] = ifc0.b_ready;
    assign ar[1] = ifc1.a_ready;
    assign br[1] = ifc1.b_ready;

    uart_tx_sched #(.DATA_W(DW), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(ifc0.slave),
        .tx(tx[0]), .busy(busy[0]), .grant_src(gsrc[0])
    );
    uart_tx_sched #(.DATA_W(DW), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(ifc1.slave),
        .tx(tx[1]), .busy(busy[1]), .grant_src(gsrc[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // stimulus state
    logic [7:0] qa [2][$];
    logic [7:0] qb [2][$];
    bit rst_r;
    bit flaky;
    int tper;
    int tcnt;

    // model: frame as a bit list, position -1 while waiting for first tick
    bit m_busy [2];
    bit m_tx [2];
    bit m_gs [2];
    bit m_last_b [2];
    int m_pos [2];
    int m_len [2];
    bit m_frame [2][16];
    bit pr_a [2];
    bit pr_b [2];

    bit cap_en;
    bit cap_q [2][$];
    bit hs_log [2][$];
    int ra_cnt [2];

    task automatic chk(input string nm, input int k,
                       input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d @%0t: got %h want %h",
                     nm, k, $time, got, exp);
        end
    endtask

    task automatic model_update(input int k);
        int sb;
        sb = (k == 0) ? 1 : 2;
        if (rst) begin
            m_busy[k] = 0;
            m_tx[k] = 1;
            m_gs[k] = 0;
            m_last_b[k] = 1;
            m_pos[k] = -1;
        end else if (!m_busy[k]) begin
            if ((pr_a[k] && av[k]) || (pr_b[k] && bv[k])) begin
                logic [7:0] d;
                bit s;
                s = pr_b[k] && bv[k];
                d = s ? bd[k] : ad[k];
                m_len[k] = 1 + DW + PAR + sb;
                m_frame[k][0] = 0;
                for (int i = 0; i < DW; i++) m_frame[k][1+i] = d[i];
                if (PAR == 1) m_frame[k][1+DW] = ^d;
                for (int i = 0; i < sb; i++) m_frame[k][1+DW+PAR+i] = 1;
                m_busy[k] = 1;
                m_pos[k] = -1;
                m_gs[k] = s;
                m_last_b[k] = s;
                hs_log[k].push_back(s);
                if (s) void'(qb[k].pop_front());
                else void'(qa[k].pop_front());
            end
        end else if (baud_tick) begin
            m_pos[k]++;
            if (m_pos[k] == m_len[k]) begin
                m_busy[k] = 0;
                m_tx[k] = 1;
            end else begin
                m_tx[k] = m_frame[k][m_pos[k]];
            end
        end
    endtask

    task automatic drive();
        rst = rst_r;
        baud_tick = (tcnt == 0);
        tcnt++;
        if (tcnt >= tper) tcnt = 0;
        for (int k = 0; k < 2; k++) begin
            av[k] = (qa[k].size() > 0) && (!flaky || $urandom_range(3) != 0);
            bv[k] = (qb[k].size() > 0) && (!flaky || $urandom_range(3) != 0);
            ad[k] = av[k] ? qa[k][0] : 8'($urandom);
            bd[k] = bv[k] ? qb[k][0] : 8'($urandom);
        end
    endtask

    task automatic check_cycle();
        for (int k = 0; k < 2; k++) begin
            bit idle, win_b;
            idle = !m_busy[k] && !rst;
            win_b = bv[k] && (!av[k] || !m_last_b[k]);
            pr_a[k] = idle && av[k] && !win_b;
            pr_b[k] = idle && win_b;
            chk("tx", k, tx[k], m_tx[k]);
            chk("busy", k, busy[k], m_busy[k]);
            chk("grant_src", k, gsrc[k], m_gs[k]);
            chk("a_ready", k, ar[k], pr_a[k]);
            chk("b_ready", k, br[k], pr_b[k]);
            if (pr_a[k]) ra_cnt[k]++;
            if (cap_en && m_busy[k]) cap_q[k].push_back(m_tx[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
        drive();
        #1;
        check_cycle();
    endtask

    task automatic do_reset();
        rst_r = 1;
        step();
        step();
        rst_r = 0;
        step();
        for (int k = 0; k < 2; k++) begin
            hs_log[k].delete();
            cap_q[k].delete();
            ra_cnt[k] = 0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (i < budget && (m_busy[0] || m_busy[1] ||
               qa[0].size() > 0 || qb[0].size() > 0 ||
               qa[1].size() > 0 || qb[1].size() > 0)) begin
            step();
            i++;
        end
        if (i >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout @%0t: still busy after %0d cycles",
                     $time, budget);
        end
        step();
    endtask

    task automatic decode(input int k, input int periods,
                          output logic [11:0] v, output int len);
        int f;
        f = 0;
        v = '0;
        while (f < cap_q[k].size() && cap_q[k][f]) f++;
        len = cap_q[k].size() - f;
        for (int i = 0; i < periods; i++)
            if (f + 4*i + 1 < cap_q[k].size()) v[i] = cap_q[k][f + 4*i + 1];
    endtask

    initial begin
        logic [11:0] v;
        int len;
        logic [11:0] exp_v [2];
        rst = 1;
        baud_tick = 0;
        av = '0;
        bv = '0;
        ad[0] = 0; ad[1] = 0; bd[0] = 0; bd[1] = 0;
        rst_r = 1;
        flaky = 0;
        tper = 4;
        tcnt = 0;
        cap_en = 0;
        for (int k = 0; k < 2; k++) begin
            pr_a[k] = 0; pr_b[k] = 0; m_busy[k] = 0; m_pos[k] = -1;
        end

        // reset state
        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx", k, tx[k], 1);
            chk("rst_busy", k, busy[k], 0);
            chk("rst_gsrc", k, gsrc[k], 0);
        end

        // single frame 0x55, tick every 4 cycles
`ifdef UART_TX_SCHED_PARITY_EN
        exp_v[0] = 12'h4AA;
        exp_v[1] = 12'hCAA;
`else
        exp_v[0] = 12'h2AA;
        exp_v[1] = 12'h6AA;
`endif
        tper = 4;
        tcnt = 0;
        cap_en = 1;
        qa[0].push_back(8'h55);
        qa[1].push_back(8'h55);
        wait_idle(400);
        cap_en = 0;
        for (int k = 0; k < 2; k++) begin
            int per;
            per = 10 + PAR + k;
            decode(k, per, v, len);
            chk("frame55_bits", k, v, exp_v[k]);
            chk("frame55_len", k, 12'(len), 12'(4 * per));
            chk("frame55_rdy1", k, 12'(ra_cnt[k]), 1);
            chk("frame55_src", k, 12'(hs_log[k].size() == 1 && hs_log[k][0] == 0), 1);
        end

        // contention right after reset: A first even though A was last served
        do_reset();
        for (int k = 0; k < 2; k++) begin
            qa[k].push_back(8'h12);
            qb[k].push_back(8'h34);
        end
        wait_idle(800);
        for (int k = 0; k < 2; k++) begin
            v = '0;
            for (int i = 0; i < hs_log[k].size() && i < 12; i++) v[i] = hs_log[k][i];
            chk("contend_order", k, v, 12'b10);
            chk("contend_cnt", k, 12'(hs_log[k].size()), 2);
        end

        // fairness: 4 bytes each, continuously valid
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                qa[k].push_back(8'(8'hA0 + i));
                qb[k].push_back(8'(8'hB0 + i));
            end
        wait_idle(3000);
        for (int k = 0; k < 2; k++) begin
            v = '0;
            for (int i = 0; i < hs_log[k].size() && i < 12; i++) v[i] = hs_log[k][i];
            chk("fair_order", k, v, 12'b1010_1010);
        end

        // reset during data bit 3, then a B-only request
        do_reset();
        qa[0].push_back(8'hA5);
        qa[1].push_back(8'hA5);
        for (int i = 0; i < 400 && !(m_busy[0] && m_pos[0] == 4); i++) step();
        chk("reach_bit3", 0, 12'(m_busy[0] && m_pos[0] == 4), 1);
        rst_r = 1;
        step();
        rst_r = 0;
        step();
        chk("midrst_tx", 0, tx[0], 1);
        chk("midrst_busy", 0, busy[0], 0);
        chk("midrst_rdy", 0, 12'({ar[0], br[0]}), 0);
        for (int k = 0; k < 2; k++) begin
            hs_log[k].delete();
            qb[k].push_back(8'hC3);
        end
        wait_idle(800);
        chk("midrst_b_src", 0, gsrc[0], 1);
        chk("midrst_b_cnt", 1, 12'(hs_log[1].size()), 1);

`ifdef UART_TX_SCHED_PARITY_EN
        do_reset();
        tcnt = 0;
        cap_en = 1;
        qa[0].push_back(8'h07);
        wait_idle(400);
        decode(0, 11, v, len);
        chk("par07", 0, v[9], 1);
        chk("par07_len", 0, 12'(len), 44);
        cap_q[0].delete();
        qa[0].push_back(8'h03);
        wait_idle(400);
        decode(0, 11, v, len);
        chk("par03", 0, v[9], 0);
        chk("par03_len", 0, 12'(len), 44);
        cap_en = 0;
`endif

        // random traffic, tick rates, valid drops and stray resets
        flaky = 1;
        for (int r = 0; r < 25; r++) begin
            tper = $urandom_range(1, 6);
            for (int k = 0; k < 2; k++) begin
                int na, nb;
                na = $urandom_range(0, 4);
                nb = $urandom_range(0, 4);
                for (int i = 0; i < na; i++) qa[k].push_back(8'($urandom));
                for (int i = 0; i < nb; i++) qb[k].push_back(8'($urandom));
            end
            for (int i = 0; i < 150; i++) begin
                rst_r = ($urandom_range(0, 199) == 0);
                step();
            end
            rst_r = 0;
            wait_idle(4000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
